// File: rtl/fp_op_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp_op_sched
// Purpose  : Single-issue scheduler in front of the FP32 arithmetic datapath.
//            Accepts one tagged operation over a valid/ready request channel,
//            holds its operands/rounding mode/tag, drives the combinational
//            units (add/mul/fma) or the multi-cycle divider (start/done),
//            strobes the shared fp_rnd result register, and returns the tag
//            over a valid/ready response channel. Counts completed responses.
// Ports    : clk_i, reset_i (sync, active-high)
//            req_*        : request channel (valid/ready, op, rnd, tag, a/b/c)
//            op_*_o, sub_o, rnd_o, unit_sel_o : registered controls to units
//            div_start_o / div_done_i        : divider handshake
//            rnd_load_o   : capture enable for the fp_rnd result register
//            resp_*       : response channel (valid/ready, tag, flags)
//            op_cnt_o     : completed-response counter (wraps)
// Options  : define FP_SCHED_DIV_TIMEOUT_EN to bound the divider wait to
//            DIV_TIMEOUT cycles and report resp_timeout_o.
// Revision : 1.0 - initial release
// ============================================================================
module fp_op_sched #(
    parameter int FP_WIDTH    = 32,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 16,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [2:0]          req_op_i,
    input  logic [2:0]          req_rnd_i,
    input  logic [TAG_W-1:0]    req_tag_i,
    input  logic [FP_WIDTH-1:0] req_a_i,
    input  logic [FP_WIDTH-1:0] req_b_i,
    input  logic [FP_WIDTH-1:0] req_c_i,
    output logic [FP_WIDTH-1:0] op_a_o,
    output logic [FP_WIDTH-1:0] op_b_o,
    output logic [FP_WIDTH-1:0] op_c_o,
    output logic                sub_o,
    output logic [2:0]          rnd_o,
    output logic [1:0]          unit_sel_o,
    output logic                div_start_o,
    input  logic                div_done_i,
    output logic                rnd_load_o,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [TAG_W-1:0]    resp_tag_o,
    output logic                resp_illegal_o,
    output logic                resp_timeout_o,
    output logic [CNT_W-1:0]    op_cnt_o
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_EXEC      = 3'd1;
    localparam logic [2:0] ST_DIV_START = 3'd2;
    localparam logic [2:0] ST_DIV_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_FMA = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;

    localparam int DIV_CNT_W = $clog2(DIV_TIMEOUT + 1);

    // A zero limit would make the timeout counter meaningless.
    if (DIV_TIMEOUT < 1) begin : g_div_timeout_range
        $error("fp_op_sched: DIV_TIMEOUT must be at least 1");
    end

    logic [2:0]          state_q,    state_d;
    logic [FP_WIDTH-1:0] op_a_q,     op_a_d;
    logic [FP_WIDTH-1:0] op_b_q,     op_b_d;
    logic [FP_WIDTH-1:0] op_c_q,     op_c_d;
    logic                sub_q,      sub_d;
    logic [2:0]          rnd_q,      rnd_d;
    logic [1:0]          unit_sel_q, unit_sel_d;
    logic [TAG_W-1:0]    tag_q,      tag_d;
    logic                illegal_q,  illegal_d;
    logic                timeout_q,  timeout_d;
    logic [CNT_W-1:0]    op_cnt_q,   op_cnt_d;
`ifdef FP_SCHED_DIV_TIMEOUT_EN
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_c_d     = op_c_q;
        sub_d      = sub_q;
        rnd_d      = rnd_q;
        unit_sel_d = unit_sel_q;
        tag_d      = tag_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        op_cnt_d   = op_cnt_q;
`ifdef FP_SCHED_DIV_TIMEOUT_EN
        div_cnt_d  = div_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_a_d     = req_a_i;
                    op_b_d     = req_b_i;
                    op_c_d     = req_c_i;
                    rnd_d      = req_rnd_i;
                    tag_d      = req_tag_i;
                    sub_d      = (req_op_i == OP_SUB);
                    illegal_d  = 1'b0;
                    timeout_d  = 1'b0;
                    unit_sel_d = 2'd0;
                    case (req_op_i)
                        OP_ADD, OP_SUB: state_d = ST_EXEC;
                        OP_MUL: begin
                            unit_sel_d = 2'd1;
                            state_d    = ST_EXEC;
                        end
                        OP_FMA: begin
                            unit_sel_d = 2'd2;
                            state_d    = ST_EXEC;
                        end
                        OP_DIV: begin
                            unit_sel_d = 2'd3;
                            state_d    = ST_DIV_START;
                        end
                        // Illegal opcodes skip the datapath entirely.
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = ST_RESP;
                        end
                    endcase
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_DIV_START: begin
`ifdef FP_SCHED_DIV_TIMEOUT_EN
                div_cnt_d = '0;
`endif
                state_d = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                // Done takes priority over an expiring limit in the same cycle.
                if (div_done_i) begin
                    state_d = ST_RESP;
                end
`ifdef FP_SCHED_DIV_TIMEOUT_EN
                else if (div_cnt_q == DIV_CNT_W'(DIV_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    op_cnt_d  = op_cnt_q + 1'b1;
                    illegal_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_c_q     <= '0;
            sub_q      <= 1'b0;
            rnd_q      <= '0;
            unit_sel_q <= '0;
            tag_q      <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            op_cnt_q   <= '0;
`ifdef FP_SCHED_DIV_TIMEOUT_EN
            div_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_c_q     <= op_c_d;
            sub_q      <= sub_d;
            rnd_q      <= rnd_d;
            unit_sel_q <= unit_sel_d;
            tag_q      <= tag_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
            op_cnt_q   <= op_cnt_d;
`ifdef FP_SCHED_DIV_TIMEOUT_EN
            div_cnt_q  <= div_cnt_d;
`endif
        end
    end

    assign req_ready_o    = (state_q == ST_IDLE);
    assign div_start_o    = (state_q == ST_DIV_START);
    // Load fp_rnd in the EXEC cycle or in the very cycle the divider reports done.
    assign rnd_load_o     = (state_q == ST_EXEC) ||
                            ((state_q == ST_DIV_WAIT) && div_done_i);
    assign resp_valid_o   = (state_q == ST_RESP);
    assign op_a_o         = op_a_q;
    assign op_b_o         = op_b_q;
    assign op_c_o         = op_c_q;
    assign sub_o          = sub_q;
    assign rnd_o          = rnd_q;
    assign unit_sel_o     = unit_sel_q;
    assign resp_tag_o     = tag_q;
    assign resp_illegal_o = illegal_q;
`ifdef FP_SCHED_DIV_TIMEOUT_EN
    assign resp_timeout_o = timeout_q;
`else
    assign resp_timeout_o = 1'b0;
`endif
    assign op_cnt_o       = op_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_op_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_op_sched
// Purpose  : Directed self-checking bench for fp_op_sched: reset values,
//            ADD/SUB/MUL/FMA control and latency, DIV handshake, response
//            backpressure, illegal opcode, reset mid-divide and (when
//            FP_SCHED_DIV_TIMEOUT_EN is defined) the divider timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_op_sched;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic [2:0]  req_rnd_i;
    logic [3:0]  req_tag_i;
    logic [31:0] req_a_i, req_b_i, req_c_i;
    logic [31:0] op_a_o, op_b_o, op_c_o;
    logic        sub_o;
    logic [2:0]  rnd_o;
    logic [1:0]  unit_sel_o;
    logic        div_start_o;
    logic        div_done_i;
    logic        rnd_load_o;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [3:0]  resp_tag_o;
    logic        resp_illegal_o;
    logic        resp_timeout_o;
    logic [15:0] op_cnt_o;

    int vectors = 0;
    int errs    = 0;

    fp_op_sched #(.FP_WIDTH(32), .TAG_W(4), .CNT_W(16), .DIV_TIMEOUT(64)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_rnd_i(req_rnd_i), .req_tag_i(req_tag_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_c_i(req_c_i),
        .op_a_o(op_a_o), .op_b_o(op_b_o), .op_c_o(op_c_o),
        .sub_o(sub_o), .rnd_o(rnd_o), .unit_sel_o(unit_sel_o),
        .div_start_o(div_start_o), .div_done_i(div_done_i),
        .rnd_load_o(rnd_load_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_tag_o(resp_tag_o), .resp_illegal_o(resp_illegal_o),
        .resp_timeout_o(resp_timeout_o), .op_cnt_o(op_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for one cycle; returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] tag,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [2:0] rnd);
        req_op_i = op; req_tag_i = tag; req_a_i = a; req_b_i = b; req_c_i = c;
        req_rnd_i = rnd; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_rnd_i = '0;
        req_tag_i = '0; req_a_i = '0; req_b_i = '0; req_c_i = '0;
        div_done_i = 1'b0; resp_ready_i = 1'b1;
        tick(); tick();
        reset_i = 1'b0;

        // ---- reset state
        chk("rst_ready",    32'(req_ready_o),    32'd1);
        chk("rst_valid",    32'(resp_valid_o),   32'd0);
        chk("rst_divstart", 32'(div_start_o),    32'd0);
        chk("rst_rndload",  32'(rnd_load_o),     32'd0);
        chk("rst_illegal",  32'(resp_illegal_o), 32'd0);
        chk("rst_timeout",  32'(resp_timeout_o), 32'd0);
        chk("rst_cnt",      32'(op_cnt_o),       32'd0);
        chk("rst_usel",     32'(unit_sel_o),     32'd0);
        chk("rst_opa",      op_a_o,              32'd0);
        chk("rst_tag",      32'(resp_tag_o),     32'd0);

        // ---- ADD: 1.0 + 2.0, tag 5
        issue(3'd0, 4'd5, 32'h3F800000, 32'h40000000, 32'h0, 3'd3);
        chk("add_rndload",  32'(rnd_load_o),  32'd1);
        chk("add_ready",    32'(req_ready_o), 32'd0);
        chk("add_valid0",   32'(resp_valid_o), 32'd0);
        chk("add_opa",      op_a_o,           32'h3F800000);
        chk("add_opb",      op_b_o,           32'h40000000);
        chk("add_rnd",      32'(rnd_o),       32'd3);
        chk("add_sub",      32'(sub_o),       32'd0);
        chk("add_usel",     32'(unit_sel_o),  32'd0);
        tick();
        chk("add_valid",    32'(resp_valid_o), 32'd1);
        chk("add_tag",      32'(resp_tag_o),   32'd5);
        chk("add_rndload1", 32'(rnd_load_o),   32'd0);
        chk("add_cnt_pre",  32'(op_cnt_o),     32'd0);
        tick();
        chk("add_cnt",      32'(op_cnt_o),     32'd1);
        chk("add_idle",     32'(req_ready_o),  32'd1);
        chk("add_valid_off",32'(resp_valid_o), 32'd0);

        // ---- SUB
        issue(3'd1, 4'd7, 32'h40400000, 32'h3F800000, 32'h0, 3'd0);
        chk("sub_sub",   32'(sub_o),       32'd1);
        chk("sub_usel",  32'(unit_sel_o),  32'd0);
        chk("sub_ready", 32'(req_ready_o), 32'd0);
        tick();
        chk("sub_ready_resp", 32'(req_ready_o), 32'd0);
        chk("sub_tag",   32'(resp_tag_o),  32'd7);
        tick();
        chk("sub_cnt",   32'(op_cnt_o),    32'd2);

        // ---- FMA
        issue(3'd3, 4'd2, 32'h40000000, 32'h40400000, 32'h3F800000, 3'd1);
        chk("fma_sub",   32'(sub_o),       32'd0);
        chk("fma_usel",  32'(unit_sel_o),  32'd2);
        chk("fma_opc",   op_c_o,           32'h3F800000);
        chk("fma_rndload", 32'(rnd_load_o), 32'd1);
        tick(); tick();
        chk("fma_cnt",   32'(op_cnt_o),    32'd3);

        // ---- MUL
        issue(3'd2, 4'd1, 32'h40000000, 32'h40000000, 32'h0, 3'd0);
        chk("mul_usel",  32'(unit_sel_o),  32'd1);
        tick(); tick();
        chk("mul_cnt",   32'(op_cnt_o),    32'd4);

        // ---- DIV with done after 10 wait cycles
        issue(3'd4, 4'd9, 32'h41200000, 32'h40000000, 32'h0, 3'd0);
        chk("div_start",  32'(div_start_o), 32'd1);
        chk("div_usel",   32'(unit_sel_o),  32'd3);
        chk("div_rndload_st", 32'(rnd_load_o), 32'd0);
        tick();
        chk("div_start_off", 32'(div_start_o), 32'd0);
        for (int i = 0; i < 9; i++) begin
            chk("div_wait_rndload", 32'(rnd_load_o),   32'd0);
            chk("div_wait_valid",   32'(resp_valid_o), 32'd0);
            tick();
        end
        div_done_i = 1'b1;
        #1;
        chk("div_done_rndload", 32'(rnd_load_o), 32'd1);
        resp_ready_i = 1'b0;
        tick();
        // done still high in RESP must be ignored
        chk("div_valid",        32'(resp_valid_o), 32'd1);
        chk("div_tag",          32'(resp_tag_o),   32'd9);
        chk("div_resp_rndload", 32'(rnd_load_o),   32'd0);
        tick();
        chk("div_second_done",  32'(resp_valid_o), 32'd1);
        div_done_i = 1'b0;
        resp_ready_i = 1'b1;
        tick();
        chk("div_cnt",  32'(op_cnt_o),    32'd5);
        chk("div_idle", 32'(req_ready_o), 32'd1);

        // ---- Backpressure: 7 stalled cycles, pending request not accepted
        resp_ready_i = 1'b0;
        issue(3'd0, 4'hA, 32'h11111111, 32'h22222222, 32'h0, 3'd0);
        req_op_i = 3'd2; req_tag_i = 4'hB; req_a_i = 32'h33333333; req_valid_i = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("bp_valid", 32'(resp_valid_o), 32'd1);
            chk("bp_tag",   32'(resp_tag_o),   32'hA);
            chk("bp_ready", 32'(req_ready_o),  32'd0);
            chk("bp_cnt",   32'(op_cnt_o),     32'd5);
            chk("bp_opa",   op_a_o,            32'h11111111);
            tick();
        end
        req_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        tick();
        chk("bp_cnt_hs", 32'(op_cnt_o),    32'd6);
        chk("bp_idle",   32'(req_ready_o), 32'd1);
        chk("bp_opa_hold", op_a_o,         32'h11111111);

        // ---- Illegal op 6
        issue(3'd6, 4'd3, 32'h0, 32'h0, 32'h0, 3'd0);
        chk("ill_valid",   32'(resp_valid_o),   32'd1);
        chk("ill_flag",    32'(resp_illegal_o), 32'd1);
        chk("ill_rndload", 32'(rnd_load_o),     32'd0);
        chk("ill_tag",     32'(resp_tag_o),     32'd3);
        tick();
        chk("ill_cnt",     32'(op_cnt_o),       32'd7);
        chk("ill_clear",   32'(resp_illegal_o), 32'd0);
        chk("ill_valid_off", 32'(resp_valid_o), 32'd0);

        // ---- Reset during DIV_WAIT
        issue(3'd4, 4'd4, 32'h0, 32'h0, 32'h0, 3'd0);
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("rstdiv_ready", 32'(req_ready_o),  32'd1);
        chk("rstdiv_cnt",   32'(op_cnt_o),     32'd0);
        chk("rstdiv_valid", 32'(resp_valid_o), 32'd0);
        chk("rstdiv_usel",  32'(unit_sel_o),   32'd0);

`ifdef FP_SCHED_DIV_TIMEOUT_EN
        // ---- Divider timeout after 64 DIV_WAIT cycles
        begin
            int n;
            logic seen_load;
            n = 0;
            seen_load = 1'b0;
            issue(3'd4, 4'd6, 32'h0, 32'h0, 32'h0, 3'd0);
            resp_ready_i = 1'b0;
            tick();
            while (resp_valid_o !== 1'b1 && n < 200) begin
                if (rnd_load_o === 1'b1) seen_load = 1'b1;
                tick();
                n++;
            end
            chk("to_cycles",  32'(n),              32'd64);
            chk("to_flag",    32'(resp_timeout_o), 32'd1);
            chk("to_noload",  32'(seen_load),      32'd0);
            resp_ready_i = 1'b1;
            tick();
            chk("to_clear",   32'(resp_timeout_o), 32'd0);
            chk("to_cnt",     32'(op_cnt_o),       32'd1);
        end
`else
        // ---- Without the timeout option the divider wait never expires
        begin
            issue(3'd4, 4'd6, 32'h0, 32'h0, 32'h0, 3'd0);
            tick();
            for (int i = 0; i < 80; i++) tick();
            chk("nto_valid",   32'(resp_valid_o),   32'd0);
            chk("nto_timeout", 32'(resp_timeout_o), 32'd0);
            div_done_i = 1'b1;
            tick();
            div_done_i = 1'b0;
            chk("nto_resp",    32'(resp_valid_o),   32'd1);
            chk("nto_timeout2",32'(resp_timeout_o), 32'd0);
            tick();
            chk("nto_cnt",     32'(op_cnt_o),       32'd1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
